inst_fetch_mem: RTL
===================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 32, instruction and PC width.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of instruction words; power of two, at least 4.
REQ-003 SHALL have parameter MEM_AW, default $clog2(MEM_DEPTH), word-index width, derived and not overridden.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have fetch-request ports:
- req_valid, input, 1, request present.
- req_ready, output, 1, request accepted this cycle.
- req_pc, input, CPU_WIDTH, byte address.
REQ-007 SHALL have fetch-response ports:
- rsp_valid, output, 1, response held.
- rsp_ready, input, 1, consumer takes response.
- rsp_inst, output, CPU_WIDTH, instruction.
- rsp_err, output, 1, fault flag.
REQ-008 SHALL have port flush, input, 1, discards any held or in-flight response.
REQ-009 SHALL, with RVSEED_IMEM_LOAD_EN only, have load ports:
- ld_en, input, 1, write strobe.
- ld_addr, input, MEM_AW, word index.
- ld_data, input, CPU_WIDTH, word to write.

Function
REQ-010 SHALL accept a request when req_valid && req_ready.
- req_ready = !flush && !ld_en && (!rsp_valid || rsp_ready).
REQ-011 SHALL present the response one cycle after acceptance: rsp_valid=1, rsp_inst = mem[req_pc[MEM_AW+1:2]].
REQ-012 SHALL keep rsp_inst and rsp_err stable while rsp_valid && !rsp_ready (single-entry output buffer).
REQ-013 SHALL allow back-to-back requests: accept in the same cycle the held response is consumed, giving one response per cycle.
REQ-014 SHALL set rsp_err=1 and force rsp_inst to the NOP constant (0x00000013, zero-extended) when either fault holds:
- req_pc[1:0] != 0 (misaligned), or
- req_pc >= MEM_DEPTH*4 (out of range).
REQ-015 SHALL implement a two-state FSM:
- EMPTY: rsp_valid=0; go to FULL on acceptance.
- FULL: rsp_valid=1; stay FULL on consume plus new acceptance; go to EMPTY on consume with no acceptance.
REQ-016 SHALL give flush priority: on flush, next state is EMPTY and no request is accepted that cycle.
REQ-017 SHALL, when ld_en=1, write ld_data into mem[ld_addr] on that edge; a fetch read of the same address in a later cycle returns the new data.
REQ-018 SHALL make rsp_err and rsp_inst don't-care when rsp_valid=0; both are held at 0 in that state for determinism.

Reset
REQ-019 SHALL, on rst_n=0, immediately and asynchronously set the FSM to EMPTY, rsp_valid=0, rsp_inst=0 and rsp_err=0; memory contents are not reset.
REQ-020 SHALL, on reset mid-response, drop the held response with no replay after reset release.
REQ-021 SHALL drive req_ready per REQ-010 from the first cycle after rst_n deasserts.

Configuration
REQ-022 SHALL, with macro RVSEED_IMEM_LOAD_EN defined, include the load port and the behaviour in REQ-017.
REQ-023 SHALL, without RVSEED_IMEM_LOAD_EN:
- omit the load ports;
- treat ld_en as 0 in REQ-010;
- leave memory contents to the testbench only, via hierarchical initialisation of the array.

Structure
REQ-024 SHALL take CPU_WIDTH, the NOP constant and the default depth from the shared rvseed_defines.v; the module declares no other global constants.
REQ-025 SHALL place storage in one sub-module, imem_array:
- one synchronous read port;
- one optional write port;
- no reset on contents.

Verification
REQ-026 SHALL cover single fetch: preload mem[3]=0xDEADBEEF, req_pc=0x0C -> next cycle rsp_valid=1, rsp_inst=0xDEADBEEF, rsp_err=0.
REQ-027 SHALL cover stall: hold rsp_ready=0 for 3 cycles after response -> req_ready=0, rsp_inst stable; release -> consumed; a new request accepted the same cycle.
REQ-028 SHALL cover streaming: PCs 0x0,0x4,0x8,0xC with rsp_ready=1 -> four consecutive responses, one per cycle, in order.
REQ-029 SHALL cover faults:
- req_pc=0x6 -> rsp_err=1, rsp_inst=0x00000013.
- req_pc=MEM_DEPTH*4 (0x400 at default depth) -> rsp_err=1, rsp_inst=0x00000013.
REQ-030 SHALL cover flush and reset with a response held:
- flush=1 -> rsp_valid=0 next cycle, req_ready=0 during flush.
- rst_n pulsed low -> rsp_valid=0 immediately, with no clock edge.
REQ-031 SHALL cover load (with RVSEED_IMEM_LOAD_EN): ld_en=1, ld_addr=5, ld_data=0x12345678 -> req_ready=0 that cycle; a later fetch of 0x14 returns 0x12345678.

Source files
------------

// File: rtl/inst_fetch_mem_pkg.sv
// inst_fetch_mem_pkg: shared widths, NOP constant and fetch FSM state type.
package inst_fetch_mem_pkg;
    localparam int          CPU_WIDTH_DEF = 32;
    localparam int          MEM_DEPTH_DEF = 256;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    typedef enum logic {EMPTY, FULL} fetch_state_t;
endpackage

// File: rtl/inst_fetch_mem_if.sv
// inst_fetch_if: fetch request/response handshake between a fetcher (master) and the instruction memory (slave).
interface inst_fetch_if
    import inst_fetch_mem_pkg::*;
#(
    parameter int CPU_WIDTH = CPU_WIDTH_DEF
);
    logic                 req_valid;
    logic                 req_ready;
    logic [CPU_WIDTH-1:0] req_pc;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CPU_WIDTH-1:0] rsp_inst;
    logic                 rsp_err;
    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );
    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/inst_fetch_mem_imem_array.sv
// imem_array: instruction storage with one synchronous read port and one write port; contents are never reset.
module imem_array
    import inst_fetch_mem_pkg::*;
#(
    parameter int CPU_WIDTH = CPU_WIDTH_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 re_i,
    input  logic [MEM_AW-1:0]    raddr_i,
    output logic [CPU_WIDTH-1:0] rdata_o,
    input  logic                 we_i,
    input  logic [MEM_AW-1:0]    waddr_i,
    input  logic [CPU_WIDTH-1:0] wdata_i
);
    logic [CPU_WIDTH-1:0] mem [MEM_DEPTH];
    logic [CPU_WIDTH-1:0] rdata_q;
    // The read register only moves on a read, so it doubles as the held response word.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: single-entry buffered instruction fetch memory with fault detection.
// Optional load port enabled by defining RVSEED_IMEM_LOAD_EN.
module inst_fetch_mem
    import inst_fetch_mem_pkg::*;
#(
    parameter int CPU_WIDTH = CPU_WIDTH_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
`ifdef RVSEED_IMEM_LOAD_EN
    input  logic                 ld_en,
    input  logic [MEM_AW-1:0]    ld_addr,
    input  logic [CPU_WIDTH-1:0] ld_data,
`endif
    inst_fetch_if.slave          bus
);
`ifndef RVSEED_IMEM_LOAD_EN
    logic                 ld_en;
    logic [MEM_AW-1:0]    ld_addr;
    logic [CPU_WIDTH-1:0] ld_data;
    assign ld_en   = 1'b0;
    assign ld_addr = '0;
    assign ld_data = '0;
`endif
    fetch_state_t         state_q, state_d;
    logic                 err_q, err_d;
    logic                 fault, accept;
    logic [CPU_WIDTH-1:0] rdata;
    // Any address bit above the word index means the PC lies beyond the array.
    assign fault = (bus.req_pc[1:0] != 2'b00) || ((bus.req_pc >> (MEM_AW + 2)) != '0);
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        bus.req_ready = !flush && !ld_en && (state_q == EMPTY || bus.rsp_ready);
        accept        = bus.req_valid && bus.req_ready;
        bus.rsp_valid = state_q == FULL;
        bus.rsp_err   = state_q == FULL && err_q;
        bus.rsp_inst  = state_q == FULL ? (err_q ? CPU_WIDTH'(NOP_INST) : rdata) : '0;
        if (flush) state_d = EMPTY;
        else if (accept) begin
            state_d = FULL;
            err_d   = fault;
        end
        else if (state_q == FULL && bus.rsp_ready) state_d = EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end
    imem_array #(
        .CPU_WIDTH (CPU_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_AW    (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .re_i    (accept),
        .raddr_i (bus.req_pc[MEM_AW+1:2]),
        .rdata_o (rdata),
        .we_i    (ld_en),
        .waddr_i (ld_addr),
        .wdata_i (ld_data)
    );
endmodule
